iccm_prog_loader: RTL and testbench

UART boot-loader framing stage for the ICCM programming path. It consumes the byte stream from the programming UART receiver, parses a length-prefixed, checksummed image frame, and emits 32-bit word writes toward the ICCM adapter's controller port. While a load is in progress it holds the rest of the system in reset, and it reports completion or error.

---
 rtl/iccm_prog_loader_if.sv | 22 ++
 rtl/iccm_prog_loader.sv | 106 ++++++++++
 tb/tb_iccm_prog_loader.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/iccm_prog_loader_if.sv
// iccm_prog_loader_if: byte stream in, ICCM word writes and load status out
interface iccm_prog_loader_if #(
    parameter int ADDR_W = 11
);
    logic              prog_i;
    logic              rx_dv_i;
    logic [7:0]        rx_byte_i;
    logic              we_o;
    logic [ADDR_W-1:0] addr_o;
    logic [31:0]       wdata_o;
    logic              sys_rst_no;
    logic              done_o;
    logic              err_o;
    modport slave (
        input  prog_i, rx_dv_i, rx_byte_i,
        output we_o, addr_o, wdata_o, sys_rst_no, done_o, err_o
    );
    modport master (
        output prog_i, rx_dv_i, rx_byte_i,
        input  we_o, addr_o, wdata_o, sys_rst_no, done_o, err_o
    );
endinterface

// File: rtl/iccm_prog_loader.sv
// iccm_prog_loader: parses a length-prefixed, XOR-checksummed UART image into ICCM word writes
module iccm_prog_loader #(
    parameter int ADDR_W         = 11,
    parameter int DEPTH          = 2048,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input logic              clk_i,
    input logic              rst_i,
    iccm_prog_loader_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, CSUM, DONE, ERR} state_t;
    state_t            state_q;
    logic              prog_q, pend_q;
    logic [15:0]       len_q;
    logic [1:0]        lane_q;
    logic [23:0]       asm_q;
    logic [31:0]       pdata_q;
    logic [ADDR_W-1:0] cnt_q, paddr_q;
    logic [7:0]        csum_q;
    logic [TW-1:0]     tmo_q;
    logic              start, last, tmo_hit, too_long;
    logic [15:0]       n;
    logic [31:0]       word;
    always_comb begin
        start    = bus.prog_i & ~prog_q;
        n        = {bus.rx_byte_i, len_q[7:0]};
        too_long = {16'h0, n} > 32'(DEPTH);
        word     = {bus.rx_byte_i, asm_q};
        last     = 32'(cnt_q) + 32'd1 == {16'h0, len_q};
        tmo_hit  = tmo_q == TW'(TIMEOUT_CYCLES - 1);
    end
    // Outputs trail the FSM by one register stage, so writes and status land a cycle after the deciding byte.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            prog_q         <= 1'b0;
            pend_q         <= 1'b0;
            len_q          <= '0;
            lane_q         <= '0;
            asm_q          <= '0;
            pdata_q        <= '0;
            cnt_q          <= '0;
            paddr_q        <= '0;
            csum_q         <= '0;
            tmo_q          <= '0;
            bus.we_o       <= 1'b0;
            bus.addr_o     <= '0;
            bus.wdata_o    <= '0;
            bus.sys_rst_no <= 1'b1;
            bus.done_o     <= 1'b0;
            bus.err_o      <= 1'b0;
        end else begin
            prog_q         <= bus.prog_i;
            pend_q         <= 1'b0;
            bus.we_o       <= pend_q;
            if (pend_q) begin
                bus.addr_o  <= paddr_q;
                bus.wdata_o <= pdata_q;
            end
            bus.sys_rst_no <= state_q == IDLE || state_q == DONE;
            bus.done_o     <= state_q == DONE;
            bus.err_o      <= state_q == ERR;
            case (state_q)
                IDLE, DONE, ERR: begin
                    cnt_q  <= '0;
                    csum_q <= '0;
                    lane_q <= '0;
                    tmo_q  <= '0;
                    if (start) state_q <= LEN0;
                end
                default: begin
                    // Abort beats a byte arriving in the same cycle; a byte beats the timeout.
                    if (!bus.prog_i) state_q <= ERR;
                    else if (bus.rx_dv_i) begin
                        tmo_q <= '0;
                        case (state_q)
                            LEN0: begin
                                len_q   <= {8'h00, bus.rx_byte_i};
                                state_q <= LEN1;
                            end
                            LEN1: begin
                                len_q   <= n;
                                state_q <= too_long ? ERR : (n == 16'h0 ? CSUM : DATA);
                            end
                            DATA: begin
                                asm_q  <= {bus.rx_byte_i, asm_q[23:8]};
                                csum_q <= csum_q ^ bus.rx_byte_i;
                                lane_q <= lane_q + 2'd1;
                                if (lane_q == 2'd3) begin
                                    pend_q  <= 1'b1;
                                    pdata_q <= word;
                                    paddr_q <= cnt_q;
                                    cnt_q   <= cnt_q + 1'b1;
                                    if (last) state_q <= CSUM;
                                end
                            end
                            default: state_q <= bus.rx_byte_i == csum_q ? DONE : ERR;
                        endcase
                    end else if (tmo_hit) state_q <= ERR;
                    else tmo_q <= tmo_q + 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_iccm_prog_loader.sv
// tb_iccm_prog_loader: directed frames checked against a frame-level model of expected writes and outcome
module tb_iccm_prog_loader;
    localparam int DEPTH = 2048;
    typedef logic [7:0] byte_t;
    typedef struct packed {logic [10:0] a; logic [31:0] d;} wr_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad = 0;
    int cyc = 0;
    wr_t exp_q[$];
    int we_times[$];
    byte_t fr[$];
    int md;
    iccm_prog_loader_if #(.ADDR_W(11)) bus ();
    iccm_prog_loader #(.ADDR_W(11), .DEPTH(DEPTH), .TIMEOUT_CYCLES(16)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask
    // Frame-level model: which words get written and whether the image ends good.
    function automatic int model(input byte_t b[$]);
        int n;
        logic [7:0] x;
        logic [31:0] w;
        if (b.size() < 2) return 0;
        n = int'(b[0]) | (int'(b[1]) << 8);
        if (n > DEPTH) return 0;
        x = 8'h00;
        for (int i = 0; i < n; i++) begin
            if (b.size() < 2 + 4 * i + 4) return 0;
            w = {b[5 + 4 * i], b[4 + 4 * i], b[3 + 4 * i], b[2 + 4 * i]};
            exp_q.push_back('{11'(i), w});
            x = x ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
        end
        if (b.size() < 2 + 4 * n + 1) return 0;
        return (b[2 + 4 * n] == x) ? 1 : 0;
    endfunction
    always @(negedge clk) begin
        if (!rst && bus.we_o) begin
            we_times.push_back(cyc);
            if (exp_q.size() == 0) chk("unexpected_we", {21'h0, bus.addr_o}, 32'hFFFFFFFF);
            else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("we_addr", {21'h0, bus.addr_o}, {21'h0, e.a});
                chk("we_data", bus.wdata_o, e.d);
            end
        end
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic start_load();
        bus.prog_i = 1'b0;
        tick();
        bus.prog_i = 1'b1;
        tick();
        tick();
    endtask
    task automatic send(input byte_t b[$], input int gap);
        foreach (b[i]) begin
            bus.rx_dv_i   = 1'b1;
            bus.rx_byte_i = b[i];
            tick();
            bus.rx_dv_i = 1'b0;
            repeat (gap) tick();
        end
    endtask
    task automatic outcome(input string nm, input int good);
        repeat (3) tick();
        @(negedge clk);
        chk({nm, "_done"}, {31'h0, bus.done_o}, good);
        chk({nm, "_err"}, {31'h0, bus.err_o}, 32'(good == 0));
        chk({nm, "_sysrst"}, {31'h0, bus.sys_rst_no}, good);
        chk({nm, "_pending"}, exp_q.size(), 0);
        tick();
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d", total);
        $fatal(1);
    end
    initial begin
        bus.prog_i = 1'b0;
        bus.rx_dv_i = 1'b0;
        bus.rx_byte_i = 8'h00;
        repeat (2) tick();
        @(negedge clk);
        chk("rst_we", {31'h0, bus.we_o}, 0);
        chk("rst_addr", {21'h0, bus.addr_o}, 0);
        chk("rst_wdata", bus.wdata_o, 0);
        chk("rst_sysrst", {31'h0, bus.sys_rst_no}, 1);
        chk("rst_done", {31'h0, bus.done_o}, 0);
        chk("rst_err", {31'h0, bus.err_o}, 0);
        rst = 1'b0;
        tick();
        // N=1 good frame with start and release latency pinned by hand
        fr = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22};
        md = model(fr);
        chk("model_word", exp_q[0].d, 32'hDEADBEEF);
        chk("model_good", md, 1);
        bus.prog_i = 1'b1;
        tick();
        @(negedge clk);
        chk("start_k", {31'h0, bus.sys_rst_no}, 1);
        tick();
        @(negedge clk);
        chk("start_k1", {31'h0, bus.sys_rst_no}, 0);
        tick();
        send(fr, 0);
        @(negedge clk);
        chk("csum_k", {31'h0, bus.sys_rst_no}, 0);
        @(negedge clk);
        chk("csum_k1", {31'h0, bus.sys_rst_no}, 1);
        chk("csum_k1_done", {31'h0, bus.done_o}, 1);
        outcome("n1", md);
        // N=0 frames, good and bad checksum
        fr = '{8'h00, 8'h00, 8'h00};
        md = model(fr);
        start_load();
        send(fr, 1);
        outcome("n0_good", md);
        fr = '{8'h00, 8'h00, 8'h01};
        md = model(fr);
        chk("model_bad", md, 0);
        start_load();
        send(fr, 1);
        outcome("n0_bad", md);
        // N=3 back-to-back, then the same with one corrupted data byte
        fr = '{8'h03, 8'h00};
        for (int i = 0; i < 12; i++) fr.push_back(8'(i));
        fr.push_back(8'h00);
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 1) fr[7] = 8'h45;
            md = model(fr);
            chk("model_w2", exp_q[2].d, 32'h0B0A0908);
            we_times.delete();
            start_load();
            send(fr, 0);
            outcome(pass == 0 ? "n3_good" : "n3_bad", md);
            chk("n3_we_count", we_times.size(), 3);
            if (we_times.size() == 3) begin
                chk("n3_gap1", we_times[1] - we_times[0], 4);
                chk("n3_gap2", we_times[2] - we_times[1], 4);
            end
        end
        // Length beyond DEPTH fails right after LEN_HI
        fr = '{8'h01, 8'h08};
        md = model(fr);
        start_load();
        send(fr, 0);
        tick();
        @(negedge clk);
        chk("len_big_err", {31'h0, bus.err_o}, 1);
        outcome("len_big", md);
        // Timeout after two data bytes, then a fresh start clears the error
        fr = '{8'h01, 8'h00, 8'hAA, 8'hBB};
        md = model(fr);
        start_load();
        send(fr, 0);
        repeat (14) tick();
        @(negedge clk);
        chk("tmo_early", {31'h0, bus.err_o}, 0);
        repeat (6) tick();
        @(negedge clk);
        chk("tmo_err", {31'h0, bus.err_o}, 1);
        outcome("tmo", md);
        start_load();
        @(negedge clk);
        chk("restart_err", {31'h0, bus.err_o}, 0);
        chk("restart_sysrst", {31'h0, bus.sys_rst_no}, 0);
        fr = '{8'h00, 8'h00, 8'h00};
        md = model(fr);
        tick();
        send(fr, 0);
        outcome("restart", md);
        // prog_i dropped after five data bytes
        fr = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        md = model(fr);
        we_times.delete();
        start_load();
        send(fr, 0);
        bus.prog_i = 1'b0;
        outcome("abort", md);
        chk("abort_we_count", we_times.size(), 1);
        // Reset while a write is in flight
        fr = '{8'h01, 8'h00, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
        md = model(fr);
        start_load();
        send(fr, 0);
        rst = 1'b1;
        #1;
        chk("mid_rst_we", {31'h0, bus.we_o}, 0);
        chk("mid_rst_addr", {21'h0, bus.addr_o}, 0);
        chk("mid_rst_wdata", bus.wdata_o, 0);
        chk("mid_rst_sysrst", {31'h0, bus.sys_rst_no}, 1);
        chk("mid_rst_done", {31'h0, bus.done_o}, 0);
        chk("mid_rst_err", {31'h0, bus.err_o}, 0);
        exp_q.delete();
        we_times.delete();
        tick();
        rst = 1'b0;
        repeat (10) tick();
        chk("mid_rst_no_we", we_times.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
